// File: rtl/membank_copy_initiator.sv
// Word-by-word memory copy engine: reads a source word, writes it to the destination,
// repeats for cmd_len words with at most one bank request in flight.
module membank_copy_initiator #(
  parameter int noLanes  = 32,
  parameter int laneSize = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_start,
  input  logic [21:0]                   cmd_src,
  input  logic [21:0]                   cmd_dst,
  input  logic [15:0]                   cmd_len,
  output logic                          busy,
  output logic                          done,
  output logic                          err_spurious,
  output logic                          mem_opreq,
  input  logic                          mem_oprdy,
  output logic                          mem_rwbar,
  output logic [21:0]                   mem_wordAddr_in,
  output logic [noLanes*laneSize-1:0]   mem_wdata_in,
  output logic [noLanes-1:0]            mem_lanes_in,
  input  logic                          mem_ack,
  input  logic [noLanes*laneSize-1:0]   mem_rdata
);

  localparam int W = noLanes * laneSize;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [21:0]          src_q, src_d;
  logic [21:0]          dst_q, dst_d;
  logic [15:0]          len_q, len_d;
  logic [W-1:0]         data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 opreq_q, opreq_d;
  logic                 rwbar_q, rwbar_d;
  logic [21:0]          addr_q, addr_d;
  logic [W-1:0]         wdata_q, wdata_d;
  logic [noLanes-1:0]   lanes_q, lanes_d;
  logic                 accept_s;

  assign accept_s = opreq_q & mem_oprdy;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          err_d = 1'b0;
          if (cmd_len != 16'd0) begin
            src_d   = cmd_src;
            dst_d   = cmd_dst;
            len_d   = cmd_len;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (accept_s) state_d = RD_WAIT;
        else          state_d = RD_REQ;
      end
      RD_WAIT: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = WR_REQ;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_REQ: begin
        if (accept_s) state_d = WR_WAIT;
        else          state_d = WR_REQ;
      end
      WR_WAIT: begin
        if (mem_ack) begin
          src_d   = src_q + 22'd1;
          dst_d   = dst_q + 22'd1;
          len_d   = len_q - 16'd1;
          state_d = (len_q == 16'd1) ? DONE : RD_REQ;
        end else begin
          state_d = WR_WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An ack with nothing outstanding is flagged; this wins over a same-cycle clear
    if (mem_ack && (state_q != RD_WAIT) && (state_q != WR_WAIT)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    busy_d  = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
              (state_d == WR_REQ) || (state_d == WR_WAIT);
    done_d  = (state_d == DONE);
    opreq_d = (state_d == RD_REQ) || (state_d == WR_REQ);
    rwbar_d = (state_d != WR_REQ);
    wdata_d = data_d;
    lanes_d = (state_d == WR_REQ) ? {noLanes{1'b1}} : {noLanes{1'b0}};

    case (state_d)
      RD_REQ:  addr_d = src_d;
      WR_REQ:  addr_d = dst_d;
      default: addr_d = addr_q;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= 22'd0;
      dst_q   <= 22'd0;
      len_q   <= 16'd0;
      data_q  <= {W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      opreq_q <= 1'b0;
      rwbar_q <= 1'b1;
      addr_q  <= 22'd0;
      wdata_q <= {W{1'b0}};
      lanes_q <= {noLanes{1'b0}};
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      opreq_q <= opreq_d;
      rwbar_q <= rwbar_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lanes_q <= lanes_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_spurious    = err_q;
  assign mem_opreq       = opreq_q;
  assign mem_rwbar       = rwbar_q;
  assign mem_wordAddr_in = addr_q;
  assign mem_wdata_in    = wdata_q;
  assign mem_lanes_in    = lanes_q;

endmodule

// File: tb/tb_membank_copy_initiator.sv
// Bench for membank_copy_initiator: a configurable-latency bank model plus a
// sequential word-copy reference, driven and sampled on the falling clock edge.
module tb_membank_copy_initiator;

  localparam int NL = 32;
  localparam int LS = 8;
  localparam int W  = NL * LS;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start;
  logic [21:0]   cmd_src, cmd_dst;
  logic [15:0]   cmd_len;
  logic          busy, done, err_spurious;
  logic          mem_opreq, mem_oprdy, mem_rwbar;
  logic [21:0]   mem_wordAddr_in;
  logic [W-1:0]  mem_wdata_in;
  logic [NL-1:0] mem_lanes_in;
  logic          mem_ack;
  logic [W-1:0]  mem_rdata;
  logic          bank_ack, spur_ack;

  assign mem_ack = bank_ack | spur_ack;

  always #5 clk = ~clk;

  membank_copy_initiator #(.noLanes(NL), .laneSize(LS)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .busy(busy), .done(done),
    .err_spurious(err_spurious), .mem_opreq(mem_opreq), .mem_oprdy(mem_oprdy),
    .mem_rwbar(mem_rwbar), .mem_wordAddr_in(mem_wordAddr_in),
    .mem_wdata_in(mem_wdata_in), .mem_lanes_in(mem_lanes_in),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        rw;
    logic [21:0] addr;
  } txn_t;

  logic [W-1:0] mem     [logic [21:0]];
  logic [W-1:0] ref_mem [logic [21:0]];
  txn_t         log_q[$];

  int           rdy_delay, ack_lat, wait_cnt, ack_cnt;
  bit           pending, pend_rw, prev_valid;
  logic [21:0]  pend_addr, prev_addr;
  logic [W-1:0] pend_wdata, prev_wdata;
  logic         prev_rw;
  int           n_cmp, n_bad;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock: wait for the falling edge, then play the bank's part for this cycle
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      pending = 1'b0; bank_ack = 1'b0; mem_oprdy = 1'b0; wait_cnt = 0; prev_valid = 1'b0;
    end else begin
      bank_ack = 1'b0;
      if (pending) begin
        if (ack_cnt == 0) begin
          bank_ack = 1'b1;
          pending  = 1'b0;
          if (pend_rw) mem_rdata = mem.exists(pend_addr) ? mem[pend_addr] : {W{1'b0}};
          else begin
            mem[pend_addr] = pend_wdata;
            mem_rdata      = rand_word();
          end
        end else begin
          ack_cnt--;
        end
      end
      if (mem_opreq) begin
        chk("one_outstanding", W'(pending), W'(1'b0));
        if (prev_valid) begin
          chk("hold_addr", W'(mem_wordAddr_in), W'(prev_addr));
          chk("hold_rwbar", W'(mem_rwbar), W'(prev_rw));
          if (!prev_rw) chk("hold_wdata", mem_wdata_in, prev_wdata);
        end
        if (wait_cnt >= rdy_delay) begin
          mem_oprdy  = 1'b1;
          pending    = 1'b1;
          ack_cnt    = ack_lat - 1;
          pend_rw    = mem_rwbar;
          pend_addr  = mem_wordAddr_in;
          pend_wdata = mem_wdata_in;
          log_q.push_back('{rw: mem_rwbar, addr: mem_wordAddr_in});
          if (!mem_rwbar) chk("write_lanes", W'(mem_lanes_in), W'({NL{1'b1}}));
          prev_valid = 1'b0;
          wait_cnt   = 0;
        end else begin
          mem_oprdy  = 1'b0;
          wait_cnt++;
          prev_valid = 1'b1;
          prev_addr  = mem_wordAddr_in;
          prev_rw    = mem_rwbar;
          prev_wdata = mem_wdata_in;
        end
      end else begin
        mem_oprdy  = 1'b0;
        wait_cnt   = 0;
        prev_valid = 1'b0;
      end
    end
  endtask

  // Full copy: completion cycle = len * 2 * ((rdy_delay + 1) + ack_lat) + 1
  task automatic run_copy(input logic [21:0] src, input logic [21:0] dst, input int len,
                          input int d, input int l, input string tag);
    int          exp_cyc, done_cyc, done_cnt, busy_bad, base;
    logic [21:0] a;
    logic [W-1:0] w;
    rdy_delay = d;
    ack_lat   = l;
    exp_cyc   = len * 2 * ((d + 1) + l) + 1;
    for (int i = 0; i < len; i++) begin
      a = 22'(src + 22'(i));
      w = rand_word();
      mem[a] = w;
      ref_mem[a] = w;
    end
    for (int i = 0; i < len; i++) ref_mem[22'(dst + 22'(i))] = ref_mem[22'(src + 22'(i))];
    base = log_q.size();
    tick();
    cmd_src = src; cmd_dst = dst; cmd_len = 16'(len); cmd_start = 1'b1;
    done_cyc = -1; done_cnt = 0; busy_bad = 0;
    for (int k = 1; k <= exp_cyc + 3; k++) begin
      tick();
      if (k <= exp_cyc) begin
        cmd_start = 1'($urandom_range(0, 1));
        cmd_src   = 22'($urandom);
        cmd_dst   = 22'($urandom);
        cmd_len   = 16'($urandom_range(0, 4));
      end else begin
        cmd_start = 1'b0;
      end
      if (k == 1) chk({tag, "_err_cleared"}, W'(err_spurious), W'(1'b0));
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (busy !== (k < exp_cyc)) busy_bad++;
    end
    cmd_start = 1'b0;
    chk({tag, "_done_cycle"}, W'(done_cyc), W'(exp_cyc));
    chk({tag, "_done_pulses"}, W'(done_cnt), W'(1));
    chk({tag, "_busy_profile"}, W'(busy_bad), W'(0));
    chk({tag, "_req_count"}, W'(log_q.size() - base), W'(2 * len));
    if (log_q.size() - base == 2 * len) begin
      for (int i = 0; i < len; i++) begin
        chk({tag, "_rd_req"}, W'(log_q[base + 2*i]), W'({1'b1, 22'(src + 22'(i))}));
        chk({tag, "_wr_req"}, W'(log_q[base + 2*i + 1]), W'({1'b0, 22'(dst + 22'(i))}));
      end
    end
    for (int i = 0; i < len; i++) begin
      a = 22'(dst + 22'(i));
      chk({tag, "_dst_word"}, mem.exists(a) ? mem[a] : {W{1'b0}}, ref_mem[a]);
    end
  endtask

  initial begin
    int base, len;
    logic [21:0] s, t;
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; cmd_start = 1'b0; cmd_src = 22'd0; cmd_dst = 22'd0; cmd_len = 16'd0;
    spur_ack = 1'b0; bank_ack = 1'b0; mem_oprdy = 1'b0; mem_rdata = {W{1'b0}};
    pending = 1'b0; prev_valid = 1'b0; wait_cnt = 0; ack_cnt = 0; rdy_delay = 0; ack_lat = 1;

    repeat (3) tick();
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_err", W'(err_spurious), W'(1'b0));
    chk("rst_opreq", W'(mem_opreq), W'(1'b0));
    chk("rst_rwbar", W'(mem_rwbar), W'(1'b1));
    chk("rst_addr", W'(mem_wordAddr_in), W'(22'd0));
    chk("rst_wdata", mem_wdata_in, {W{1'b0}});
    chk("rst_lanes", W'(mem_lanes_in), W'({NL{1'b0}}));
    reset = 1'b1;
    tick();

    run_copy(22'd10, 22'd100, 3, 0, 1, "basic");
    run_copy(22'd5, 22'd200, 0, 0, 1, "len0");
    run_copy(22'd300, 22'd400, 2, 3, 5, "slow");
    run_copy(22'h3FFFFE, 22'd500, 3, 0, 1, "wrap");

    // Stray ack while idle
    tick(); spur_ack = 1'b1;
    tick(); spur_ack = 1'b0;
    tick();
    chk("spur_set", W'(err_spurious), W'(1'b1));
    chk("spur_idle", W'(busy), W'(1'b0));
    repeat (3) tick();
    chk("spur_sticky", W'(err_spurious), W'(1'b1));
    run_copy(22'd40, 22'd900, 1, 0, 1, "after_spur");

    // Reset dropped during the second word's write wait
    rdy_delay = 0; ack_lat = 1;
    for (int i = 0; i < 3; i++) mem[22'(600 + i)] = rand_word();
    base = log_q.size();
    tick();
    cmd_src = 22'd600; cmd_dst = 22'd700; cmd_len = 16'd3; cmd_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      cmd_start = 1'b0;
      chk("abort_pre_nodone", W'(done), W'(1'b0));
    end
    chk("abort_in_wr_wait", W'(log_q.size() - base), W'(4));
    chk("abort_busy_before", W'(busy), W'(1'b1));
    reset = 1'b0; bank_ack = 1'b0; pending = 1'b0;
    #1;
    chk("abort_opreq", W'(mem_opreq), W'(1'b0));
    chk("abort_busy", W'(busy), W'(1'b0));
    chk("abort_addr", W'(mem_wordAddr_in), W'(22'd0));
    repeat (2) begin
      tick();
      chk("abort_nodone", W'(done), W'(1'b0));
    end
    reset = 1'b1;
    tick(); spur_ack = 1'b1;
    tick(); spur_ack = 1'b0;
    tick();
    chk("late_ack_err", W'(err_spurious), W'(1'b1));
    run_copy(22'd600, 22'd800, 3, 0, 1, "post_reset");

    for (int r = 0; r < 6; r++) begin
      s   = 22'($urandom);
      t   = 22'($urandom);
      len = $urandom_range(1, 5);
      run_copy(s, t, len, $urandom_range(0, 2), $urandom_range(1, 4), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
